// File: rtl/button_debouncer_if.sv
// Button-side signal bundle: raw pins in, debounced levels and press/release events out.
interface button_debouncer_if #(
  parameter int NUM_BUTTONS = 4
);
  localparam int IDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

  logic [NUM_BUTTONS-1:0] btn_raw;
  logic [NUM_BUTTONS-1:0] btn_stable;
  logic [NUM_BUTTONS-1:0] btn_press;
  logic [NUM_BUTTONS-1:0] btn_release;
  logic                   btn_valid;
  logic [IDX_W-1:0]       btn_index;

  modport master (
    input  btn_raw,
    output btn_stable, btn_press, btn_release, btn_valid, btn_index
  );

  modport slave (
    output btn_raw,
    input  btn_stable, btn_press, btn_release, btn_valid, btn_index
  );
endinterface

// File: rtl/button_debouncer.sv
// Synchronises and debounces push buttons against a millisecond tick, emitting
// stable levels, one-cycle press/release pulses and an encoded press event.
module button_debouncer #(
  parameter int NUM_BUTTONS = 4,
  parameter int DEBOUNCE_MS = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          ticks_per_milli,
  button_debouncer_if.master  buttons
);

  localparam int IDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic [NUM_BUTTONS-1:0] sync_pipe [SYNC_STAGES];
  logic [NUM_BUTTONS-1:0] sync;

  logic [5:0] presc;
  logic       ms_tick;

  logic [CNT_W-1:0]       cnt      [NUM_BUTTONS];
  logic [CNT_W-1:0]       cnt_next [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] stable, stable_next;
  logic [NUM_BUTTONS-1:0] press, press_next;
  logic [NUM_BUTTONS-1:0] release_q, release_next;
  logic                   valid, valid_next;
  logic [IDX_W-1:0]       index, index_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_pipe[s] <= '0;
    end else begin
      sync_pipe[0] <= buttons.btn_raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_pipe[s] <= sync_pipe[s-1];
    end
  end

  assign sync = sync_pipe[SYNC_STAGES-1];

  // >= rather than == so a shrinking ticks_per_milli still wraps promptly.
  always_comb begin
    ms_tick = (ticks_per_milli <= 6'd1) || (presc >= (ticks_per_milli - 6'd1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          presc <= '0;
    else if (ms_tick) presc <= '0;
    else              presc <= presc + 6'd1;
  end

  always_comb begin
    stable_next  = stable;
    press_next   = '0;
    release_next = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      cnt_next[i] = cnt[i];
      if (sync[i] == stable[i]) begin
        cnt_next[i] = '0;
      end else if (ms_tick) begin
        if (cnt[i] == CNT_LAST) begin
          cnt_next[i]     = '0;
          stable_next[i]  = sync[i];
          press_next[i]   = sync[i];
          release_next[i] = ~sync[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Lowest set press bit wins; index stays 0 when nothing is pressed.
  always_comb begin
    valid_next = |press_next;
    index_next = '0;
    for (int unsigned i = NUM_BUTTONS; i > 0; i--) begin
      if (press_next[i-1]) index_next = IDX_W'(i - 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) cnt[i] <= '0;
      stable    <= '0;
      press     <= '0;
      release_q <= '0;
      valid     <= 1'b0;
      index     <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) cnt[i] <= cnt_next[i];
      stable    <= stable_next;
      press     <= press_next;
      release_q <= release_next;
      valid     <= valid_next;
      index     <= index_next;
    end
  end

  assign buttons.btn_stable  = stable;
  assign buttons.btn_press   = press;
  assign buttons.btn_release = release_q;
  assign buttons.btn_valid   = valid;
  assign buttons.btn_index   = index;

endmodule
